pre_alloc_multi: RTL

//  Parametrised N-port entry pre-allocator for the MSHR and other entry pools.

---
 rtl/pre_alloc_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pre_alloc_multi.sv
// rtl/pre_alloc_multi.sv - N-port free-entry pre-allocator; optional round-robin search via PRE_ALLOC_RR_EN
module pre_alloc_multi #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int PORT_NUM       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ENTRY_NUM-1:0]               v_in_vld,
    output logic [ENTRY_NUM-1:0]               v_in_rdy,
    input  logic                               flush,
    output logic [PORT_NUM-1:0]                out_vld,
    input  logic [PORT_NUM-1:0]                out_rdy,
    output logic [PORT_NUM*ENTRY_ID_WIDTH-1:0] out_idx
);

    logic [PORT_NUM-1:0]       slot_vld;
    logic [ENTRY_ID_WIDTH-1:0] slot_idx [PORT_NUM];

    logic [PORT_NUM:0]         rdy_prefix;
    logic [PORT_NUM-1:0]       fire;
    logic [PORT_NUM-1:0]       slot_open;
    logic [ENTRY_NUM-1:0]      held_mask;
    logic [ENTRY_NUM-1:0]      avail;
    logic [PORT_NUM-1:0]       grant;
    logic [ENTRY_ID_WIDTH-1:0] grant_idx [PORT_NUM];
    logic                      any_claim;
    logic [ENTRY_ID_WIDTH-1:0] last_idx;
    logic [ENTRY_ID_WIDTH-1:0] pos;
    int                        pos_sum;

`ifdef PRE_ALLOC_RR_EN
    logic [ENTRY_ID_WIDTH-1:0] rr_ptr;
`endif

    // Port k is offered only when every lower port is ready, keeping issue in port order.
    always_comb begin
        rdy_prefix    = '0;
        rdy_prefix[0] = 1'b1;
        out_vld       = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            out_vld[k]      = slot_vld[k] & rdy_prefix[k] & ~flush;
            rdy_prefix[k+1] = rdy_prefix[k] & out_rdy[k];
        end
    end

    assign fire      = out_vld & out_rdy;
    assign slot_open = ~slot_vld | fire;

    always_comb begin
        held_mask = '0;
        v_in_rdy  = '0;
        out_idx   = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (slot_vld[k]) held_mask[slot_idx[k]] = 1'b1;
            if (fire[k])     v_in_rdy[slot_idx[k]]  = 1'b1;
            out_idx[k*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH] = slot_idx[k];
        end
    end

    // Open slots take candidates in ascending port order; firing slots stay masked so no ID is reissued.
    always_comb begin
        avail     = v_in_vld & ~held_mask;
        grant     = '0;
        any_claim = 1'b0;
        last_idx  = '0;
        pos       = '0;
        pos_sum   = 0;
        for (int k = 0; k < PORT_NUM; k++) begin
            grant_idx[k] = '0;
        end
        for (int k = 0; k < PORT_NUM; k++) begin
            if (slot_open[k] && !flush) begin
                for (int j = 0; j < ENTRY_NUM; j++) begin
`ifdef PRE_ALLOC_RR_EN
                    pos_sum = int'(rr_ptr) + j;
                    if (pos_sum >= ENTRY_NUM) pos_sum = pos_sum - ENTRY_NUM;
`else
                    pos_sum = j;
`endif
                    pos = ENTRY_ID_WIDTH'(pos_sum);
                    if (!grant[k] && avail[pos]) begin
                        grant[k]     = 1'b1;
                        grant_idx[k] = pos;
                        avail[pos]   = 1'b0;
                    end
                end
                if (grant[k]) begin
                    any_claim = 1'b1;
                    last_idx  = grant_idx[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
            for (int k = 0; k < PORT_NUM; k++) begin
                slot_idx[k] <= '0;
            end
        end else if (flush) begin
            slot_vld <= '0;
        end else begin
            for (int k = 0; k < PORT_NUM; k++) begin
                if (slot_open[k]) begin
                    slot_vld[k] <= grant[k];
                    if (grant[k]) slot_idx[k] <= grant_idx[k];
                end
            end
        end
    end

`ifdef PRE_ALLOC_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_claim) begin
            if (last_idx == ENTRY_ID_WIDTH'(ENTRY_NUM - 1)) rr_ptr <= '0;
            else                                            rr_ptr <= last_idx + ENTRY_ID_WIDTH'(1);
        end
    end
`endif

endmodule
